// File: rtl/iq_sched_ctrl.sv
// Issue-queue slot allocator and oldest-ready selector: allocates the lowest free slot, picks the oldest ready slot.
// Outputs are combinational from registered occupancy/age state; enq_ready depends only on occupancy, never on issue_ready.
module iq_sched_ctrl #(
   parameter int DEPTH = 8,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             enq_req,
   output logic             enq_ready,
   output logic [DEPTH-1:0] enq_alloc_oh,
   output logic [IDX_W-1:0] enq_alloc_idx,
   input  logic [DEPTH-1:0] slot_ready,
   output logic             issue_valid,
   input  logic             issue_ready,
   output logic [DEPTH-1:0] issue_oh,
   output logic [DEPTH-1:0] issue_strobe,
   output logic [IDX_W-1:0] issue_idx,
   output logic [IDX_W:0]   occupancy
);

   logic [DEPTH-1:0]            occ;
   logic [DEPTH-1:0][DEPTH-1:0] age;
   logic [DEPTH-1:0][DEPTH-1:0] age_nxt;
   logic [DEPTH-1:0]            free_oh;
   logic [DEPTH-1:0]            cand;
   logic [DEPTH-1:0]            sel;
   logic                        blocked;
   logic                        enq_fire;
   logic                        issue_fire;

   // Descending scan so the last hit is the lowest-numbered free slot.
   always_comb begin
      free_oh       = '0;
      enq_alloc_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!occ[i]) begin
            free_oh       = '0;
            free_oh[i]    = 1'b1;
            enq_alloc_idx = IDX_W'(i);
         end
      end
   end

   assign enq_ready    = (occupancy != (IDX_W+1)'(DEPTH));
   assign enq_fire     = enq_req & enq_ready & ~flush;
   assign enq_alloc_oh = free_oh & {DEPTH{enq_fire}};

   assign cand = occ & slot_ready;

   // A candidate wins when no other candidate is older than it.
   always_comb begin
      sel       = '0;
      issue_idx = '0;
      blocked   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && cand[j] && age[j][i]) blocked = 1'b1;
         end
         sel[i] = cand[i] & ~blocked;
         if (sel[i]) issue_idx = IDX_W'(i);
      end
   end

   assign issue_oh     = sel;
   assign issue_valid  = (|cand) & ~flush;
   assign issue_fire   = issue_valid & issue_ready;
   assign issue_strobe = sel & {DEPTH{issue_fire}};

   // New entry becomes younger than every current occupant.
   always_comb begin
      age_nxt = age;
      for (int k = 0; k < DEPTH; k++) begin
         if (enq_alloc_oh[k]) begin
            age_nxt[k] = '0;
            for (int i = 0; i < DEPTH; i++) begin
               if (i != k && occ[i]) age_nxt[i][k] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         occ       <= '0;
         age       <= '0;
         occupancy <= '0;
      end else if (flush) begin
         occ       <= '0;
         occupancy <= '0;
      end else begin
         occ       <= (occ | enq_alloc_oh) & ~issue_strobe;
         age       <= age_nxt;
         occupancy <= occupancy + (IDX_W+1)'(enq_fire) - (IDX_W+1)'(issue_fire);
      end
   end

endmodule

// File: tb/tb_iq_sched_ctrl.sv
// Bench for iq_sched_ctrl: age-ordered queue model, per-cycle compare, directed then random stimulus.
module tb_iq_sched_ctrl;
   localparam int D = 4;
   localparam int W = 2;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         flush = 1'b0;
   logic         enq_req = 1'b0;
   logic         enq_ready;
   logic [D-1:0] enq_alloc_oh;
   logic [W-1:0] enq_alloc_idx;
   logic [D-1:0] slot_ready = '0;
   logic         issue_valid;
   logic         issue_ready = 1'b0;
   logic [D-1:0] issue_oh;
   logic [D-1:0] issue_strobe;
   logic [W-1:0] issue_idx;
   logic [W:0]   occupancy;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model: occupied slots listed oldest first, plus an occupied flag per slot.
   int q[$];
   bit occm[D];

   iq_sched_ctrl #(.DEPTH(D), .IDX_W(W)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush), .enq_req(enq_req),
      .enq_ready(enq_ready), .enq_alloc_oh(enq_alloc_oh), .enq_alloc_idx(enq_alloc_idx),
      .slot_ready(slot_ready), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_oh(issue_oh), .issue_strobe(issue_strobe), .issue_idx(issue_idx),
      .occupancy(occupancy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int model_free();
      for (int i = 0; i < D; i++) if (!occm[i]) return i;
      return -1;
   endfunction

   function automatic int model_sel();
      for (int p = 0; p < q.size(); p++) if (slot_ready[q[p]]) return q[p];
      return -1;
   endfunction

   always @(posedge clock or negedge reset_n) begin : mdl
      int lf, s, pos;
      bit ef, isf;
      if (!reset_n) begin
         q.delete();
         for (int i = 0; i < D; i++) occm[i] = 1'b0;
      end else if (flush) begin
         q.delete();
         for (int i = 0; i < D; i++) occm[i] = 1'b0;
      end else begin
         lf  = model_free();
         s   = model_sel();
         ef  = enq_req && (q.size() != D);
         isf = (s >= 0) && issue_ready;
         if (isf) begin
            pos = -1;
            for (int p = 0; p < q.size(); p++) if (q[p] == s) pos = p;
            if (pos >= 0) q.delete(pos);
            occm[s] = 1'b0;
         end
         if (ef) begin
            q.push_back(lf);
            occm[lf] = 1'b1;
         end
      end
   end

   always @(negedge clock) begin : cmp
      int lf, s;
      bit rdy, ef, fnd, iv;
      if (chk_en && reset_n) begin
         lf  = model_free();
         s   = model_sel();
         rdy = (q.size() != D);
         ef  = enq_req && rdy && !flush;
         fnd = (s >= 0);
         iv  = fnd && !flush;
         chk("occupancy", int'(occupancy), q.size());
         chk("enq_ready", int'(enq_ready), int'(rdy));
         chk("enq_alloc_oh", int'(enq_alloc_oh), ef ? (1 << lf) : 0);
         if (ef) chk("enq_alloc_idx", int'(enq_alloc_idx), lf);
         chk("issue_valid", int'(issue_valid), int'(iv));
         chk("issue_oh", int'(issue_oh), fnd ? (1 << s) : 0);
         chk("issue_idx", int'(issue_idx), fnd ? s : 0);
         chk("issue_strobe", int'(issue_strobe), (iv && issue_ready) ? (1 << s) : 0);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit er, input logic [D-1:0] sr, input bit ir, input bit fl);
      enq_req     = er;
      slot_ready  = sr;
      issue_ready = ir;
      flush       = fl;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_enq_ready"}, int'(enq_ready), 1);
      chk({tag, "_occupancy"}, int'(occupancy), 0);
      chk({tag, "_enq_alloc_oh"}, int'(enq_alloc_oh), 0);
      chk({tag, "_enq_alloc_idx"}, int'(enq_alloc_idx), 0);
      chk({tag, "_issue_valid"}, int'(issue_valid), 0);
      chk({tag, "_issue_oh"}, int'(issue_oh), 0);
      chk({tag, "_issue_strobe"}, int'(issue_strobe), 0);
      chk({tag, "_issue_idx"}, int'(issue_idx), 0);
   endtask

   initial begin
      #2;
      chk_reset_outputs("rst");
      #1 reset_n = 1'b1;
      chk_en = 1'b1;
      tick();

      // Fill: lowest free slot each time, then full.
      for (int k = 0; k < D; k++) begin
         drive(1, 4'b0000, 0, 0);
         #1 chk("fill_idx", int'(enq_alloc_idx), k);
         chk("fill_oh", int'(enq_alloc_oh), 1 << k);
         tick();
      end
      chk("full_occ", int'(occupancy), 4);
      chk("full_ready", int'(enq_ready), 0);
      drive(1, 4'b0000, 0, 0);
      #1 chk("fifth_enq_oh", int'(enq_alloc_oh), 0);
      tick();

      // Oldest ready first; no combinational enq_ready from the issue.
      drive(0, 4'b1010, 1, 0);
      #1 chk("iss_a_idx", int'(issue_idx), 1);
      chk("iss_a_strobe", int'(issue_strobe), 4'b0010);
      chk("iss_a_ready", int'(enq_ready), 0);
      tick();
      chk("iss_b_occ", int'(occupancy), 3);
      chk("iss_b_ready", int'(enq_ready), 1);
      chk("iss_b_idx", int'(issue_idx), 3);
      tick();
      chk("iss_c_occ", int'(occupancy), 2);

      // Three occupied (0,2,1), then flush with enq_req and ready slots.
      drive(1, 4'b0000, 0, 0);
      #1 chk("pre_flush_idx", int'(enq_alloc_idx), 1);
      tick();
      drive(1, 4'b1111, 1, 1);
      #1 chk("flush_enq_oh", int'(enq_alloc_oh), 0);
      chk("flush_iv", int'(issue_valid), 0);
      chk("flush_strobe", int'(issue_strobe), 0);
      tick();
      chk("post_flush_occ", int'(occupancy), 0);
      for (int k = 0; k < D; k++) begin
         drive(1, 4'b0000, 0, 0);
         #1 chk("refill_idx", int'(enq_alloc_idx), k);
         tick();
      end

      // Issue slot 0, re-enqueue into it: it becomes youngest.
      drive(0, 4'b0001, 1, 0);
      #1 chk("iss0_idx", int'(issue_idx), 0);
      tick();
      drive(1, 4'b0000, 0, 0);
      #1 chk("reenq_idx", int'(enq_alloc_idx), 0);
      tick();
      begin
         int order[4] = '{1, 2, 3, 0};
         for (int k = 0; k < 4; k++) begin
            drive(0, 4'b1111, 1, 0);
            #1 chk("age_order", int'(issue_idx), order[k]);
            tick();
         end
      end
      chk("drained_occ", int'(occupancy), 0);

      // Stall: selection moves to newly woken older slot, no strobe.
      for (int k = 0; k < 3; k++) begin
         drive(1, 4'b0000, 0, 0);
         tick();
      end
      drive(0, 4'b0100, 0, 0);
      #1 chk("stall_idx_a", int'(issue_idx), 2);
      chk("stall_iv", int'(issue_valid), 1);
      chk("stall_strobe_a", int'(issue_strobe), 0);
      tick();
      drive(0, 4'b0110, 0, 0);
      #1 chk("stall_idx_b", int'(issue_idx), 1);
      chk("stall_strobe_b", int'(issue_strobe), 0);
      tick();
      drive(0, 4'b0110, 1, 0);
      #1 chk("stall_release", int'(issue_strobe), 4'b0010);
      tick();

      // Simultaneous enqueue and issue at occupancy 2.
      chk("sim_pre_occ", int'(occupancy), 2);
      drive(1, 4'b0100, 1, 0);
      #1 chk("sim_alloc", int'(enq_alloc_idx), 1);
      chk("sim_issue", int'(issue_idx), 2);
      tick();
      chk("sim_occ", int'(occupancy), 2);

      // Asynchronous reset between edges.
      drive(0, 4'b1111, 0, 0);
      #2 reset_n = 1'b0;
      #1 chk_reset_outputs("arst");
      reset_n = 1'b1;
      tick();

      for (int c = 0; c < 3000; c++) begin
         drive(($urandom % 4) != 0, 4'($urandom), ($urandom % 3) != 0, ($urandom % 60) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/iq_sched_ctrl.md
# iq_sched_ctrl

Allocation and select controller for one issue queue built from `iq_entry` slots. It owns slot occupancy and relative age, and steers each enqueue into the lowest-numbered free slot. Each cycle it picks the oldest operand-ready slot for the attached functional unit. Its outputs drive each slot's `enq_valid` and `issuing` strobes. It sits between dispatch and the issue-queue slot array.

## Interface
- `DEPTH`, default 8: number of `iq_entry` slots; power of two, 2..16.
- `IDX_W`, default `$clog2(DEPTH)`: slot index width.
- `clock`  in  1: clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: pipeline flush; synchronous; empties the queue.
- `enq_req`  in  1: dispatch offers one instruction this cycle.
- `enq_ready`  out  1: at least one slot is free; enqueue fires on `enq_req & enq_ready & ~flush`.
- `enq_alloc_oh`  out  DEPTH: one-hot slot write strobe (wired to the slots' `enq_valid`); zero unless enqueue fires.
- `enq_alloc_idx`  out  IDX_W: index of the allocated slot; valid when enqueue fires.
- `slot_ready`  in  DEPTH: the slots' `ready_to_go` vector.
- `issue_valid`  out  1: a selected slot is presented to the FU.
- `issue_ready`  in  1: the FU accepts; issue fires on `issue_valid & issue_ready`.
- `issue_oh`  out  DEPTH: one-hot selected slot; wired to the slots' `issuing` only when issue fires (strobe = `issue_oh & {DEPTH{fire}}`, output as `issue_strobe`).
- `issue_strobe`  out  DEPTH: gated issue strobe to the slots.
- `issue_idx`  out  IDX_W: index of `issue_oh`, used as the read-mux select.
- `occupancy`  out  IDX_W+1: number of occupied slots.

## Operation
- State:
  - `occ[DEPTH]`: occupied bits.
  - `age[DEPTH][DEPTH]`: `age[i][j]=1` means slot i is older than slot j.
  - `occupancy` counter.
- Allocation:
  - `free = ~occ`; the allocated slot is the lowest set bit of `free`.
  - A slot freed by an issue this cycle is not reusable until the next cycle.
- On enqueue fire into slot k:
  - set `occ[k]`;
  - set `age[i][k]=1` for every i≠k with `occ[i]`;
  - clear `age[k][*]`.
  - The new slot is therefore younger than all current occupants.
- Select:
  - `cand = occ & slot_ready`.
  - Slot i is selected when `cand[i]` is set and no j≠i has both `cand[j]` and `age[j][i]`.
  - At most one slot matches; `issue_valid = |cand & ~flush`.
  - The selection is combinational. It may change between cycles while stalled, because newly woken older slots take priority. The FU samples only on fire.
- On issue fire of slot s: clear `occ[s]`. Age bits of freed slots are don't-care, because they are rewritten on allocation.
- `occupancy` next value = `occupancy + enq_fire - issue_fire`, computed in IDX_W+1 bits. It never exceeds DEPTH and never underflows.
- `enq_ready = (occupancy != DEPTH)`.
- Flush takes priority over everything:
  - `occ` and `occupancy` go to 0;
  - `enq_alloc_oh`, `issue_valid` and `issue_strobe` are forced to 0 in the flush cycle;
  - `age` is left unchanged.
- Simultaneous enqueue and issue:
  - both take effect;
  - occupancy is unchanged;
  - the enqueued slot cannot be the issued slot.

## Timing
- Reset values:
  - `occ=0`, `occupancy=0`, `age=0`;
  - `enq_ready=1`;
  - `enq_alloc_oh=0`, `enq_alloc_idx=0`;
  - `issue_valid=0`, `issue_oh=0`, `issue_strobe=0`, `issue_idx=0`.
- An enqueue at cycle t writes the slot at the edge ending t. The slot is selectable at t+1 at the earliest, if `slot_ready` is set.
- An issue fire at cycle t clears `occ` at the edge ending t. The slot is allocatable at t+1.
- When full, an issue at t makes `enq_ready=1` at t+1; it is not asserted combinationally in cycle t.
- Deasserting `reset_n` mid-operation clears all state immediately (asynchronous).
- No combinational path from `issue_ready` to `enq_ready` or `enq_alloc_oh`.

## Test plan
- Reset, then enqueue 4 instructions on consecutive cycles (DEPTH=4) → `enq_alloc_idx` = 0,1,2,3; `occupancy`=4; `enq_ready`=0 from the next cycle; a fifth `enq_req` is not allocated.
- Full queue, `slot_ready`=4'b1010, `issue_ready`=1 → slot 1 (the oldest ready) issues; the next cycle slot 3 issues; `occupancy` goes 4→3→2.
- Issue slot 0, then enqueue → new slot 0 is youngest. With all slots ready, issue order is 1,2,3,0.
- Stall: `issue_ready`=0 with only slot 2 ready, then slot 1 becomes ready → `issue_idx` changes 2→1. `issue_strobe` stays 0 until `issue_ready`=1.
- Same cycle enqueue and issue with `occupancy`=2 → `occupancy` stays 2; the allocated index is not equal to the issued index.
- Assert `flush` with 3 occupied and `enq_req`=1 → no strobes in the flush cycle; `occupancy`=0 the next cycle; the next enqueue goes to slot 0. Asynchronous `reset_n` pulse mid-stream → all outputs return to their reset values immediately.
